// File: rtl/par_acc_window_ctrl_pkg.sv
// Shared definitions for the par_acc controller family: the 2-bit state
// encodings every par_acc controller agrees on.
package par_acc_window_ctrl_pkg;

   localparam int         STATE_W  = 2;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : par_acc_window_ctrl_pkg

// File: rtl/popcount_lanes.sv
// Combinational ones-count across the stochastic bit lanes of one sample.
module popcount_lanes #(
   parameter int LANES = 8
) (
   input  logic [LANES-1:0]             lanes,
   output logic [$clog2(LANES+1)-1:0]   count
);

   localparam int CNT_W = $clog2(LANES + 1);

   // Sum every lane bit into a count wide enough for the all-ones case.
   always_comb begin
      // NOTE: count is given a value before the loop so every path assigns it and no latch is inferred.
      count = '0;
      for (int i = 0; i < LANES; i++) begin
         count = count + CNT_W'(lanes[i]);
      end
   end

endmodule : popcount_lanes

// File: rtl/par_acc_window_ctrl.sv
// Window controller: counts ones over win_len valid samples with saturation,
// then offers the count until the consumer takes it.
module par_acc_window_ctrl
   import par_acc_window_ctrl_pkg::*;
#(
   parameter int LANES = 8,
   parameter int WIDTH = 8,
   parameter int LEN_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] win_len,
   input  logic             abort,
   input  logic [LANES-1:0] data_in,
   input  logic             data_valid,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             overflow
);

   localparam int PC_W  = $clog2(LANES + 1);
   localparam int SUM_W = WIDTH + 1;

   localparam logic [SUM_W-1:0] ACC_MAX = {1'b0, {WIDTH{1'b1}}};

   logic [STATE_W-1:0] state;
   logic [WIDTH-1:0]   acc;
   logic [LEN_W-1:0]   remaining;
   logic               ovf;

   logic [PC_W-1:0]    pc_count;
   logic [SUM_W-1:0]   sum;
   logic               sat;

   popcount_lanes #(.LANES(LANES)) u_popcount (
      .lanes (data_in),
      .count (pc_count)
   );

   // One extra bit of headroom makes the saturation compare exact.
   always_comb begin
      sum = {1'b0, acc} + SUM_W'(pc_count);
      sat = (sum > ACC_MAX);
   end

   // FSM, remaining-sample counter, saturating accumulator and sticky overflow.
   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state     <= ST_IDLE;
         acc       <= '0;
         remaining <= '0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc <= '0;
                  ovf <= 1'b0;
                  if (win_len != '0) begin
                     remaining <= win_len;
                     state     <= ST_ACCUM;
                  end else begin
                     state     <= ST_DONE;
                  end
               end
            end
            ST_ACCUM: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (data_valid) begin
                  if (sat) begin
                     acc <= ACC_MAX[WIDTH-1:0];
                     ovf <= 1'b1;
                  end else begin
                     acc <= sum[WIDTH-1:0];
                  end
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (result_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs are direct decodes of registered state.
   always_comb begin
      busy         = (state == ST_ACCUM);
      result_valid = (state == ST_DONE);
      result       = acc;
      overflow     = ovf;
   end

endmodule : par_acc_window_ctrl

// File: tb/tb_par_acc_window_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a transaction-level model that keeps the exact
// (unsaturated) ones total of the current window.
module tb_par_acc_window_ctrl;

   localparam int LANES = 8;
   localparam int WIDTH = 8;
   localparam int LEN_W = 10;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] win_len;
   logic             abort;
   logic [LANES-1:0] data_in;
   logic             data_valid;
   logic             busy;
   logic [WIDTH-1:0] result;
   logic             result_valid;
   logic             result_ready;
   logic             overflow;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   // Model: is a window open, is a result on offer, samples still needed,
   // and the true ones total of the latest window (never saturated).
   bit m_open  = 1'b0;
   bit m_offer = 1'b0;
   int m_left  = 0;
   int m_total = 0;

   par_acc_window_ctrl #(.LANES(LANES), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .win_len      (win_len),
      .abort        (abort),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat_val(input int total);
      return (total > MAXV) ? MAXV : total;
   endfunction

   // Advance the model by one clock from the inputs that were presented.
   task automatic model_step();
      if (rst) begin
         m_open = 0; m_offer = 0; m_left = 0; m_total = 0;
      end else if (m_open) begin
         if (abort) m_open = 0;
         else if (data_valid) begin
            m_total += $countones(data_in);
            m_left--;
            if (m_left == 0) begin
               m_open  = 0;
               m_offer = 1;
            end
         end
      end else if (m_offer) begin
         if (result_ready) m_offer = 0;
      end else if (start) begin
         m_total = 0;
         if (win_len == 0) m_offer = 1;
         else begin
            m_open = 1;
            m_left = int'(win_len);
         end
      end
   endtask

   // Present one cycle of inputs, clock it, update the model.
   task automatic drive(input bit st, input int wl, input bit ab, input bit dv,
                        input int din, input bit rr, input bit rs);
      start        = st;
      win_len      = LEN_W'(wl);
      abort        = ab;
      data_valid   = dv;
      data_in      = LANES'(din);
      result_ready = rr;
      rst          = rs;
      @(posedge clk);
      model_step();
      cmp_en = 1'b1;
      #2;
   endtask

   task automatic idle_cycle();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("busy", int'(busy), int'(m_open));
         check("result_valid", int'(result_valid), int'(m_offer));
         check("overflow", int'(overflow), int'(m_total > MAXV));
         if (m_offer) check("result", int'(result), sat_val(m_total));
      end
   end

   initial begin
      int dv_pat[5];
      int hold_result;

      // Reset state.
      drive(0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 1);
      check("rst_busy", int'(busy), 0);
      check("rst_rv", int'(result_valid), 0);
      check("rst_result", int'(result), 0);
      check("rst_ovf", int'(overflow), 0);
      idle_cycle();

      // win_len=4, samples 0xFF,0x0F,0x01,0x00 -> 13.
      drive(1, 4, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 'hFF, 0, 0);
      drive(0, 0, 0, 1, 'h0F, 0, 0);
      drive(0, 0, 0, 1, 'h01, 0, 0);
      check("w4_rv_before_last", int'(result_valid), 0);
      drive(0, 0, 0, 1, 'h00, 0, 0);
      check("w4_model", m_total, 13);
      check("w4_rv", int'(result_valid), 1);
      check("w4_result", int'(result), 13);
      check("w4_ovf", int'(overflow), 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      check("w4_back_idle", int'(result_valid), 0);

      // win_len=3, valid 1,0,1,0,1 with 0x03 -> 6, rises after 3rd valid.
      dv_pat = '{1, 0, 1, 0, 1};
      drive(1, 3, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         check("w3_rv_early", int'(result_valid), 0);
         drive(0, 0, 0, dv_pat[i][0], 'h03, 0, 0);
      end
      check("w3_rv", int'(result_valid), 1);
      check("w3_result", int'(result), 6);
      drive(0, 0, 0, 0, 0, 1, 0);

      // win_len=40 all ones -> saturates at 255 with overflow.
      drive(1, 40, 0, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) drive(0, 0, 0, 1, 'hFF, 0, 0);
      check("w40_model", m_total, 320);
      check("w40_result", int'(result), 255);
      check("w40_ovf", int'(overflow), 1);
      drive(0, 0, 0, 0, 0, 1, 0);
      check("w40_ovf_held_idle", int'(overflow), 1);
      drive(1, 2, 0, 0, 0, 0, 0);
      check("restart_clears_ovf", int'(overflow), 0);
      drive(0, 0, 0, 1, 'h01, 0, 0);
      drive(0, 0, 0, 1, 'h01, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0);

      // win_len=0 -> DONE with 0, stable while result_ready low.
      drive(1, 0, 0, 0, 0, 0, 0);
      hold_result = int'(result);
      check("w0_result", hold_result, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         check("w0_rv_stable", int'(result_valid), 1);
         check("w0_result_stable", int'(result), hold_result);
      end
      drive(0, 0, 0, 0, 0, 1, 0);
      check("w0_to_idle", int'(result_valid), 0);

      // Abort in the final accumulate cycle wins over completion.
      drive(1, 2, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 'h0F, 0, 0);
      drive(0, 0, 1, 1, 'h0F, 0, 0);
      check("abort_busy", int'(busy), 0);
      check("abort_rv", int'(result_valid), 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      check("abort_no_result", int'(result_valid), 0);

      // Reset mid-window discards it.
      drive(1, 5, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 'hAA, 0, 0);
      drive(0, 0, 0, 1, 'hAA, 0, 1);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_rv", int'(result_valid), 0);
      check("rst_mid_result", int'(result), 0);

      // start pulses and win_len changes during ACCUM/DONE are ignored.
      drive(1, 3, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 1, 'h07, 0, 0);
      drive(1, 9, 0, 1, 'h07, 0, 0);
      check("ign_still_busy", int'(busy), 1);
      drive(1, 1, 0, 1, 'h07, 0, 0);
      check("ign_result", int'(result), 9);
      drive(1, 0, 0, 0, 0, 0, 0);
      check("ign_done_held", int'(result_valid), 1);
      drive(0, 0, 0, 0, 0, 1, 0);

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         drive($urandom_range(0, 3) == 0,
               ($urandom_range(0, 7) == 0) ? $urandom_range(30, 80) : $urandom_range(0, 6),
               $urandom_range(0, 40) == 0,
               $urandom_range(0, 9) < 7,
               $urandom,
               $urandom_range(0, 1),
               $urandom_range(0, 300) == 0);
      end

      @(posedge clk);
      #2;
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_par_acc_window_ctrl
